// File: rtl/param_register_file.sv
// Purpose : multi-port register file with byte-enable writes and a per-register busy scoreboard.
// Latency : reads, busy flags and reserve_conflict are combinational; writes and reserves land on the next rising clk edge.
// Backpr. : none -- every write and reserve is accepted; reserve_conflict is an advisory flag only.
//
// Ports:
//   clk, rst_n                    clock, asynchronous active-low reset (clears data and busy bits)
//   RegWrite, write_address,
//   write_data, write_be          byte-masked write into one register
//   read_sel_1/2 -> read_data_1/2 two independent combinational read ports
//   reserve_en, reserve_addr      mark a register as awaiting a future write (sets busy)
//   busy_1/2                      busy status of the register selected on each read port
//   reserve_conflict              reserve request targets a register that is already busy
module param_register_file #(
    parameter int data_width   = 32,
    parameter int select_width = 5,
    parameter int zero_reg     = 1,
    parameter int bypass       = 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      RegWrite,
    input  logic [select_width-1:0]   write_address,
    input  logic [data_width-1:0]     write_data,
    input  logic [data_width/8-1:0]   write_be,
    input  logic [select_width-1:0]   read_sel_1,
    input  logic [select_width-1:0]   read_sel_2,
    output logic [data_width-1:0]     read_data_1,
    output logic [data_width-1:0]     read_data_2,
    input  logic                      reserve_en,
    input  logic [select_width-1:0]   reserve_addr,
    output logic                      busy_1,
    output logic                      busy_2,
    output logic                      reserve_conflict
);

    localparam int depth  = 2**select_width;
    localparam int nbytes = data_width/8;

    logic [data_width-1:0] r_mem [depth];
    logic [depth-1:0]      r_busy;

    logic                  w_wr_ok;
    logic                  w_rsv_ok;
    logic [data_width-1:0] w_wr_merged;
    logic                  w_fwd_1;
    logic                  w_fwd_2;

    // Register 0 is excluded from both writes and reserves when hardwired to zero,
    // which keeps its storage and busy bit permanently cleared.
    assign w_wr_ok  = RegWrite   & ~((zero_reg != 0) && (write_address == '0));
    assign w_rsv_ok = reserve_en & ~((zero_reg != 0) && (reserve_addr  == '0));

    // Byte merge of the incoming write over the current contents; shared by the
    // storage update and the same-cycle forwarding path.
    always_comb begin
        w_wr_merged = r_mem[write_address];
        for (int b = 0; b < nbytes; b++) begin
            if (write_be[b]) begin
                w_wr_merged[b*8 +: 8] = write_data[b*8 +: 8];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < depth; i++) begin
                r_mem[i] <= '0;
            end
            r_busy <= '0;
        end else begin
            if (w_wr_ok) begin
                r_mem[write_address]  <= w_wr_merged;
                r_busy[write_address] <= 1'b0;
            end
            // Placed after the write clear so a same-cycle reserve of the same
            // register wins and leaves it busy.
            if (w_rsv_ok) begin
                r_busy[reserve_addr] <= 1'b1;
            end
        end
    end

    // Forwarding is masked in reset so nothing but zeros is visible then.
    assign w_fwd_1 = (bypass != 0) && rst_n && w_wr_ok && (write_address == read_sel_1);
    assign w_fwd_2 = (bypass != 0) && rst_n && w_wr_ok && (write_address == read_sel_2);

    always_comb begin
        read_data_1 = '0;
        read_data_2 = '0;
        if (rst_n) begin
            if (w_fwd_1) begin
                read_data_1 = w_wr_merged;
            end else if (!((zero_reg != 0) && (read_sel_1 == '0))) begin
                read_data_1 = r_mem[read_sel_1];
            end
            if (w_fwd_2) begin
                read_data_2 = w_wr_merged;
            end else if (!((zero_reg != 0) && (read_sel_2 == '0))) begin
                read_data_2 = r_mem[read_sel_2];
            end
        end
    end

    // A forwarded write hides the busy bit it is about to clear, unless a
    // same-cycle reserve of that register is going to keep it set.
    always_comb begin
        busy_1 = 1'b0;
        busy_2 = 1'b0;
        if (rst_n) begin
            busy_1 = r_busy[read_sel_1];
            busy_2 = r_busy[read_sel_2];
            if (w_fwd_1 && !(w_rsv_ok && (reserve_addr == read_sel_1))) begin
                busy_1 = 1'b0;
            end
            if (w_fwd_2 && !(w_rsv_ok && (reserve_addr == read_sel_2))) begin
                busy_2 = 1'b0;
            end
        end
    end

    assign reserve_conflict = rst_n & w_rsv_ok & r_busy[reserve_addr];

endmodule

// File: tb/tb_param_register_file.sv
// Purpose : directed self-checking bench for param_register_file (bypass and non-bypass instances).
// Latency : checks combinational outputs 1 ns after inputs change or after the rising edge.
// Backpr. : not applicable.
module tb_param_register_file;

    logic        clk;
    logic        rst_n;
    logic        RegWrite;
    logic [4:0]  write_address;
    logic [31:0] write_data;
    logic [3:0]  write_be;
    logic [4:0]  read_sel_1;
    logic [4:0]  read_sel_2;
    logic        reserve_en;
    logic [4:0]  reserve_addr;

    logic [31:0] rd1_b, rd2_b, rd1_n, rd2_n;
    logic        busy1_b, busy2_b, busy1_n, busy2_n;
    logic        conf_b, conf_n;

    int n_pass  = 0;
    int n_total = 0;

    param_register_file #(.data_width(32), .select_width(5), .zero_reg(1), .bypass(1)) dut (
        .clk(clk), .rst_n(rst_n), .RegWrite(RegWrite), .write_address(write_address),
        .write_data(write_data), .write_be(write_be), .read_sel_1(read_sel_1),
        .read_sel_2(read_sel_2), .read_data_1(rd1_b), .read_data_2(rd2_b),
        .reserve_en(reserve_en), .reserve_addr(reserve_addr), .busy_1(busy1_b),
        .busy_2(busy2_b), .reserve_conflict(conf_b)
    );

    param_register_file #(.data_width(32), .select_width(5), .zero_reg(1), .bypass(0)) dut_nb (
        .clk(clk), .rst_n(rst_n), .RegWrite(RegWrite), .write_address(write_address),
        .write_data(write_data), .write_be(write_be), .read_sel_1(read_sel_1),
        .read_sel_2(read_sel_2), .read_data_1(rd1_n), .read_data_2(rd2_n),
        .reserve_en(reserve_en), .reserve_addr(reserve_addr), .busy_1(busy1_n),
        .busy_2(busy2_n), .reserve_conflict(conf_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        RegWrite     = 1'b0;
        write_address= '0;
        write_data   = '0;
        write_be     = '0;
        reserve_en   = 1'b0;
        reserve_addr = '0;
    endtask

    initial begin
        rst_n = 1'b0;
        idle();
        read_sel_1 = '0;
        read_sel_2 = '0;

        // Reset, then sweep every index on both ports of both instances.
        step();
        step();
        read_sel_1 = 5'd7;
        #1 chk("reset_outputs_low", {rd1_b, busy1_b, conf_b, rd1_n, busy1_n}, 64'h0);
        rst_n = 1'b1;
        for (int i = 0; i < 32; i++) begin
            read_sel_1 = 5'(i);
            read_sel_2 = 5'(i);
            #1 chk($sformatf("post_reset_idx%0d", i),
                   {rd1_b ^ rd2_b ^ rd1_n ^ rd2_n, (rd1_b | rd2_b | rd1_n | rd2_n) != 0,
                    busy1_b, busy2_b, busy1_n, busy2_n}, 64'h0);
        end

        // Full write then single-byte write to reg 5.
        RegWrite = 1'b1; write_address = 5'd5; write_data = 32'hDEADBEEF; write_be = 4'hF;
        step();
        write_data = 32'h000000AA; write_be = 4'h1;
        step();
        idle();
        read_sel_1 = 5'd5; read_sel_2 = 5'd5;
        #1 chk("be_merge_reg5_p1", rd1_b, 32'hDEADBEAA);
        chk("be_merge_reg5_p2", rd2_b, 32'hDEADBEAA);
        chk("be_merge_reg5_nb", rd1_n, 32'hDEADBEAA);

        // Same-cycle forwarding of a full write to reg 7.
        read_sel_1 = 5'd7;
        RegWrite = 1'b1; write_address = 5'd7; write_data = 32'h00001234; write_be = 4'hF;
        #1 chk("bypass_fwd_reg7", rd1_b, 32'h00001234);
        chk("nobypass_old_reg7", rd1_n, 32'h0);
        step();
        idle();
        #1 chk("nobypass_after_edge_reg7", rd1_n, 32'h00001234);

        // Forwarding of a partial write shows the byte-merged value.
        read_sel_2 = 5'd5;
        RegWrite = 1'b1; write_address = 5'd5; write_data = 32'h00110000; write_be = 4'b0100;
        #1 chk("bypass_merge_reg5", rd2_b, 32'hDE11BEAA);
        chk("nobypass_merge_old_reg5", rd2_n, 32'hDEADBEAA);
        step();
        idle();
        #1 chk("merge_stored_reg5", rd2_n, 32'hDE11BEAA);

        // Register 0 ignores writes and reserves.
        read_sel_1 = 5'd0;
        RegWrite = 1'b1; write_address = 5'd0; write_data = 32'hFFFFFFFF; write_be = 4'hF;
        reserve_en = 1'b1; reserve_addr = 5'd0;
        #1 chk("zero_same_cycle", {rd1_b, busy1_b, conf_b}, 64'h0);
        step();
        #1 chk("zero_after_edge", {rd1_b, busy1_b, conf_b, rd1_n, busy1_n, conf_n}, 64'h0);
        idle();

        // Reserve reg 3 twice: second request flags a conflict.
        read_sel_1 = 5'd3;
        reserve_en = 1'b1; reserve_addr = 5'd3;
        #1 chk("first_reserve_no_conflict", conf_b, 1'b0);
        step();
        chk("reserve3_busy", busy1_b, 1'b1);
        chk("reserve3_conflict", {conf_b, conf_n}, 2'b11);
        step();
        idle();
        #1 chk("conflict_keeps_busy", {busy1_b, busy1_n}, 2'b11);

        // Write with no byte enables: data unchanged, busy still cleared.
        RegWrite = 1'b1; write_address = 5'd3; write_data = 32'hFFFFFFFF; write_be = 4'h0;
        #1 chk("bypass_hides_busy3", busy1_b, 1'b0);
        chk("nobypass_busy3_until_edge", busy1_n, 1'b1);
        chk("be0_bypass_data3", rd1_b, 32'h0);
        step();
        idle();
        #1 chk("write_clears_busy3", {busy1_b, busy1_n, rd1_b, rd1_n}, 66'h0);

        // Same-cycle reserve and write: reserve wins, data still written.
        RegWrite = 1'b1; write_address = 5'd3; write_data = 32'h0000CAFE; write_be = 4'hF;
        reserve_en = 1'b1; reserve_addr = 5'd3;
        step();
        idle();
        #1 chk("rsv_wr_busy3", {busy1_b, busy1_n}, 2'b11);
        chk("rsv_wr_data3", rd1_n, 32'h0000CAFE);

        // Reg 9 busy holding 0x55, then an asynchronous reset pulse between edges.
        read_sel_1 = 5'd9; read_sel_2 = 5'd5;
        RegWrite = 1'b1; write_address = 5'd9; write_data = 32'h00000055; write_be = 4'hF;
        step();
        idle();
        reserve_en = 1'b1; reserve_addr = 5'd9;
        step();
        idle();
        #1 chk("reg9_busy_pre_reset", {rd1_n, busy1_n}, {32'h55, 1'b1});
        rst_n = 1'b0;
        #1 chk("async_reset_reg9", {rd1_b, busy1_b, rd1_n, busy1_n}, 66'h0);
        rst_n = 1'b1;
        #1 chk("reset_cleared_storage", {rd1_n, busy1_n, rd2_n}, 65'h0);

        // Writes and reserves held across an edge during reset are discarded.
        rst_n = 1'b0;
        RegWrite = 1'b1; write_address = 5'd9; write_data = 32'h00000077; write_be = 4'hF;
        reserve_en = 1'b1; reserve_addr = 5'd9;
        #1 chk("reset_conflict_low", {conf_b, conf_n, busy1_n, rd1_n}, 35'h0);
        step();
        idle();
        rst_n = 1'b1;
        #1 chk("reset_discards_write", {rd1_b, busy1_b, rd1_n, busy1_n}, 66'h0);

        // First edge after reset release takes effect.
        RegWrite = 1'b1; write_address = 5'd9; write_data = 32'h000000C3; write_be = 4'h1;
        step();
        idle();
        #1 chk("write_after_release", {rd1_b, rd1_n}, {32'hC3, 32'hC3});

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
